frame_sequencer: RTL and testbench

Controller that sequences the still-frame processing pipeline: it arms on a camera frame boundary, opens the static-frame BRAM write window for exactly one full camera frame, then launches the Sobel pass and the template-match pass in turn, waiting for each engine's done handshake. It sits between the OV7670 capture path (VSYNC), the static BRAM write-enable gate, the Sobel engine and the template matcher. It replaces ad-hoc address-compare write-enable toggling with an explicit state machine, an optional watchdog and status outputs for LEDs.

---
 rtl/frame_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
//
// Sequences the still-frame pipeline. It arms on a camera frame boundary and
// opens the static BRAM write window for exactly one camera frame. It then
// starts the Sobel pass and the template-match pass in turn, waiting for each
// engine's done pulse. Completed passes are counted, and the current state is
// exported for the debug LEDs.
//
// Optional feature: define FRAME_SEQ_WATCHDOG_EN to enable a per-engine
// watchdog. It forces FAULT if an engine stays silent for TIMEOUT_CYCLES.
// Without the macro, FAULT is unreachable and fault is tied low.
//
// Ports:
//   clk          system clock (clk_50 domain)
//   reset        asynchronous, active-high reset
//   run          level: keep running passes back to back while high
//   single       one-cycle pulse: request exactly one pass
//   cam_vsync    raw OV7670 VSYNC (asynchronous); a rising edge is a frame boundary
//   static_we    static BRAM write window (ANDed with capture_we outside)
//   sobel_start  one-cycle start pulse to the Sobel engine
//   sobel_done   one-cycle completion pulse from the Sobel engine
//   match_start  one-cycle start pulse to the template matcher
//   match_done   one-cycle completion pulse from the template matcher
//   pass_done    one-cycle pulse when a full pass completes
//   busy         high in every state except IDLE and FAULT
//   fault        watchdog fault flag
//   state        current state encoding
//   frame_count  number of completed passes (wraps)
// ---------------------------------------------------------------------------
module frame_sequencer #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000,
   parameter int unsigned FCOUNT_W       = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                single,
   input  logic                cam_vsync,
   output logic                static_we,
   output logic                sobel_start,
   input  logic                sobel_done,
   output logic                match_start,
   input  logic                match_done,
   output logic                pass_done,
   output logic                busy,
   output logic                fault,
   output logic [2:0]          state,
   output logic [FCOUNT_W-1:0] frame_count
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SOBEL   = 3'd3,
      ST_MATCH   = 3'd4,
      ST_DONE    = 3'd5,
      ST_FAULT   = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic                  one_shot_q, one_shot_d;
   logic                  static_we_q, static_we_d;
   logic                  sobel_start_q, sobel_start_d;
   logic                  match_start_q, match_start_d;
   logic                  pass_done_q, pass_done_d;
   logic                  busy_q, busy_d;
   logic [FCOUNT_W-1:0]   frame_count_q, frame_count_d;
   logic                  vs_meta_q, vs_sync_q, vs_prev_q;
   logic                  vs_rise;
   logic                  wd_expired;

   // The VSYNC synchronizer and edge flops reset high. A VSYNC that is
   // already high when reset releases therefore does not look like a frame
   // boundary.
   assign vs_rise = vs_sync_q & ~vs_prev_q;

   // Next-state logic. A done pulse is ignored while the start pulse is still
   // out, so an engine answering in the start cycle cannot skip a stage.
   always_comb begin
      state_d    = state_q;
      one_shot_d = one_shot_q;
      case (state_q)
         ST_IDLE: begin
            if (run || single) begin
               state_d    = ST_ARM;
               one_shot_d = single & ~run;
            end
         end
         ST_ARM: begin
            if (vs_rise) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (vs_rise) state_d = ST_SOBEL;
         end
         ST_SOBEL: begin
            if (sobel_done && !sobel_start_q) state_d = ST_MATCH;
            else if (wd_expired)              state_d = ST_FAULT;
         end
         ST_MATCH: begin
            if (match_done && !match_start_q) state_d = ST_DONE;
            else if (wd_expired)              state_d = ST_FAULT;
         end
         ST_DONE: begin
            state_d = (run && !one_shot_q) ? ST_ARM : ST_IDLE;
         end
         ST_FAULT: begin
            if (!run && !single) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so that they are registered
      // and change on the same edge as the state itself.
      static_we_d   = (state_d == ST_CAPTURE);
      sobel_start_d = (state_d == ST_SOBEL) && (state_q != ST_SOBEL);
      match_start_d = (state_d == ST_MATCH) && (state_q != ST_MATCH);
      pass_done_d   = (state_d == ST_DONE);
      busy_d        = (state_d != ST_IDLE) && (state_d != ST_FAULT);
      frame_count_d = pass_done_d ? frame_count_q + FCOUNT_W'(1) : frame_count_q;
   end

   // State, registered outputs and VSYNC synchronizer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         one_shot_q    <= 1'b0;
         static_we_q   <= 1'b0;
         sobel_start_q <= 1'b0;
         match_start_q <= 1'b0;
         pass_done_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
         vs_meta_q     <= 1'b1;
         vs_sync_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         one_shot_q    <= one_shot_d;
         static_we_q   <= static_we_d;
         sobel_start_q <= sobel_start_d;
         match_start_q <= match_start_d;
         pass_done_q   <= pass_done_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_d;
         vs_meta_q     <= cam_vsync;
         vs_sync_q     <= vs_meta_q;
         vs_prev_q     <= vs_sync_q;
      end
   end

`ifdef FRAME_SEQ_WATCHDOG_EN
   logic [23:0] wd_q, wd_d;
   logic        fault_q, fault_d;

   // The watchdog restarts from zero on entry to each engine wait state and
   // counts every cycle spent there. The done check wins if both happen in
   // the same cycle.
   always_comb begin
      wd_d = '0;
      if (((state_d == ST_SOBEL) || (state_d == ST_MATCH)) && (state_d == state_q)) begin
         wd_d = wd_q + 24'd1;
      end
      fault_d = (state_d == ST_FAULT);
   end

   assign wd_expired = (wd_q == TIMEOUT_CYCLES);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   logic [23:0] unused_timeout;

   assign unused_timeout = TIMEOUT_CYCLES;
   assign wd_expired     = 1'b0;
   assign fault          = 1'b0;
`endif

   assign static_we   = static_we_q;
   assign sobel_start = sobel_start_q;
   assign match_start = match_start_q;
   assign pass_done   = pass_done_q;
   assign busy        = busy_q;
   assign state       = state_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_sequencer
//
// Scoreboard bench for frame_sequencer. Every stimulus step pushes the state
// transitions, pass counts and capture-window lengths it implies. A monitor
// on the falling clock edge pops these entries and compares them as the DUT
// produces them. A VSYNC generator provides a frame boundary every 20 cycles.
// Engine models answer each start pulse after a fixed or random delay.
// ---------------------------------------------------------------------------
module tb_frame_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic       single;
   logic       cam_vsync;
   logic       static_we;
   logic       sobel_start;
   logic       sobel_done;
   logic       match_start;
   logic       match_done;
   logic       pass_done;
   logic       busy;
   logic       fault;
   logic [2:0] state;
   logic [7:0] frame_count;

   logic       sd_auto;
   logic       sd_inj;
   logic       md_auto;
   logic       vs_en;
   logic       vs_manual;
   logic       eng_en;
   int         eng_delay;
   int         gen_cnt;
   int         total_checks;
   int         bad_checks;
   int         exp_fc;

   logic [2:0] exp_states[$];
   logic [7:0] exp_fc_q[$];
   int         exp_cap_q[$];

   assign sobel_done = sd_auto | sd_inj;
   assign match_done = md_auto;

   frame_sequencer #(
      .TIMEOUT_CYCLES(24'd16),
      .FCOUNT_W      (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .single     (single),
      .cam_vsync  (cam_vsync),
      .static_we  (static_we),
      .sobel_start(sobel_start),
      .sobel_done (sobel_done),
      .match_start(match_start),
      .match_done (match_done),
      .pass_done  (pass_done),
      .busy       (busy),
      .fault      (fault),
      .state      (state),
      .frame_count(frame_count)
   );

   // 100 MHz-style clock, rising edge active
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sets run, and optionally pulses single for exactly one cycle
   task automatic applyStimulus(input logic r, input logic s);
      @(posedge clk);
      #1;
      run    = r;
      single = s;
      if (s) begin
         @(posedge clk);
         #1 single = 1'b0;
      end
   endtask

   // Drives the manual VSYNC level for the next cycle
   task automatic stepVs(input logic v);
      @(posedge clk);
      #1 vs_manual = v;
   endtask

   // Waits, with a bound, until the state matches, then records the result
   task automatic waitState(input logic [2:0] target, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((state !== target) && (n < budget));
      checkOutput(tag, 32'(state), 32'(target));
   endtask

   // Queues everything one full pass should produce
   task automatic expectPass(input bit to_idle);
      exp_states.push_back(3'd1);
      exp_states.push_back(3'd2);
      exp_states.push_back(3'd3);
      exp_states.push_back(3'd4);
      exp_states.push_back(3'd5);
      if (to_idle) exp_states.push_back(3'd0);
      exp_fc = (exp_fc + 1) & 255;
      exp_fc_q.push_back(8'(exp_fc));
      exp_cap_q.push_back(20);
   endtask

   // VSYNC source: either follows the manual level, or produces 10 low then
   // 10 high cycles, so rising edges are exactly 20 cycles apart
   initial begin
      cam_vsync = 1'b1;
      gen_cnt   = 0;
      forever begin
         @(posedge clk);
         #2;
         if (vs_en) begin
            cam_vsync = (gen_cnt < 10) ? 1'b0 : 1'b1;
            gen_cnt   = (gen_cnt + 1) % 20;
         end else begin
            cam_vsync = vs_manual;
            gen_cnt   = 0;
         end
      end
   end

   // Sobel engine model
   initial begin
      int d;
      sd_auto = 1'b0;
      forever begin
         @(negedge clk);
         if (sobel_start && eng_en) begin
            d = (eng_delay != 0) ? eng_delay : int'($urandom_range(1, 6));
            repeat (d) @(posedge clk);
            #1 sd_auto = 1'b1;
            @(posedge clk);
            #1 sd_auto = 1'b0;
         end
      end
   end

   // Template matcher model
   initial begin
      int d;
      md_auto = 1'b0;
      forever begin
         @(negedge clk);
         if (match_start) begin
            d = (eng_delay != 0) ? eng_delay : int'($urandom_range(1, 6));
            repeat (d) @(posedge clk);
            #1 md_auto = 1'b1;
            @(posedge clk);
            #1 md_auto = 1'b0;
         end
      end
   end

   // Scoreboard monitor: state transitions, pass pulses, capture windows
   initial begin
      logic [2:0] prev_state;
      int         cap_len;
      prev_state = 3'd0;
      cap_len    = 0;
      forever begin
         @(negedge clk);
         if (state !== prev_state) begin
            if (exp_states.size() == 0) checkOutput("state_unexpected", 32'(state), 32'(prev_state));
            else                        checkOutput("state_seq", 32'(state), 32'(exp_states.pop_front()));
            prev_state = state;
         end
         if (reset) begin
            cap_len = 0;
         end else begin
            if (pass_done) begin
               checkOutput("pass_state", 32'(state), 32'd5);
               if (exp_fc_q.size() == 0) checkOutput("pass_unexpected", 32'd1, 32'd0);
               else                      checkOutput("frame_count", 32'(frame_count), 32'(exp_fc_q.pop_front()));
            end
            if (static_we) begin
               cap_len++;
            end else if (cap_len != 0) begin
               if (exp_cap_q.size() == 0) checkOutput("capture_unexpected", 32'(cap_len), 32'd0);
               else                       checkOutput("capture_len", 32'(cap_len), 32'(exp_cap_q.pop_front()));
               cap_len = 0;
            end
         end
      end
   end

   initial begin
      reset        = 1'b0;
      run          = 1'b1;
      single       = 1'b0;
      vs_en        = 1'b0;
      vs_manual    = 1'b1;
      sd_inj       = 1'b0;
      eng_en       = 1'b1;
      eng_delay    = 5;
      total_checks = 0;
      bad_checks   = 0;
      exp_fc       = 0;

      // Reset with VSYNC and run already high
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_static_we", 32'(static_we), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_pass_done", 32'(pass_done), 32'd0);
      checkOutput("rst_sobel_start", 32'(sobel_start), 32'd0);
      checkOutput("rst_match_start", 32'(match_start), 32'd0);
      checkOutput("rst_frame_count", 32'(frame_count), 32'd0);

      exp_states.push_back(3'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) stepVs(1'b1);
      @(negedge clk);
      checkOutput("arm_hold", 32'(state), 32'd1);
      checkOutput("arm_static_we", 32'(static_we), 32'd0);
      checkOutput("arm_busy", 32'(busy), 32'd1);

      // Manual frame boundary; this pass finishes in IDLE because run drops
      repeat (5) stepVs(1'b0);
      exp_states.push_back(3'd2);
      exp_states.push_back(3'd3);
      exp_states.push_back(3'd4);
      exp_states.push_back(3'd5);
      exp_states.push_back(3'd0);
      exp_fc = 1;
      exp_fc_q.push_back(8'd1);
      exp_cap_q.push_back(20);
      stepVs(1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("vs_edge2", 32'(state), 32'd1);
      @(posedge clk);
      @(negedge clk);
      checkOutput("vs_edge3", 32'(state), 32'd2);
      checkOutput("vs_edge3_we", 32'(static_we), 32'd1);
      run = 1'b0;
      for (int k = 4; k <= 20; k++) stepVs((k < 10) ? 1'b1 : ((k < 20) ? 1'b0 : 1'b1));
      waitState(3'd0, 100, "A_idle");

      // Single pass; a second single during CAPTURE must be ignored
      @(posedge clk);
      #1 vs_en = 1'b1;
      expectPass(1'b1);
      applyStimulus(1'b0, 1'b1);
      waitState(3'd2, 100, "B_capture");
      applyStimulus(1'b0, 1'b1);
      waitState(3'd5, 200, "B_done");
      waitState(3'd0, 5, "B_idle");
      repeat (30) @(negedge clk);
      checkOutput("B_no_rearm", 32'(state), 32'd0);
      checkOutput("B_frame_count", 32'(frame_count), 32'(exp_fc));

      // Continuous run; drop run in the third SOBEL
      eng_delay = 0;
      expectPass(1'b0);
      expectPass(1'b0);
      expectPass(1'b1);
      applyStimulus(1'b1, 1'b0);
      waitState(3'd5, 200, "C_pass1");
      waitState(3'd5, 200, "C_pass2");
      waitState(3'd3, 200, "C_sobel3");
      run = 1'b0;
      waitState(3'd0, 200, "C_idle");
      repeat (50) @(negedge clk);
      checkOutput("C_no_fourth", 32'(state), 32'd0);
      checkOutput("C_frame_count", 32'(frame_count), 32'(exp_fc));

      // Done in the start cycle is ignored; then the engine stays silent
      eng_en = 1'b0;
      exp_states.push_back(3'd1);
      exp_states.push_back(3'd2);
      exp_states.push_back(3'd3);
      exp_cap_q.push_back(20);
      applyStimulus(1'b1, 1'b0);
      waitState(3'd3, 200, "D_sobel");
      checkOutput("D_start_first", 32'(sobel_start), 32'd1);
      sd_inj = 1'b1;
      @(posedge clk);
      #1 sd_inj = 1'b0;
      @(negedge clk);
      checkOutput("D_start_once", 32'(sobel_start), 32'd0);
      repeat (8) @(negedge clk);
      checkOutput("D_hold", 32'(state), 32'd3);
      checkOutput("D_busy", 32'(busy), 32'd1);
      checkOutput("D_no_fault", 32'(fault), 32'd0);
`ifdef FRAME_SEQ_WATCHDOG_EN
      repeat (7) @(negedge clk);
      checkOutput("D_wd_last", 32'(state), 32'd3);
      exp_states.push_back(3'd6);
      waitState(3'd6, 1, "D_fault");
      checkOutput("D_fault_flag", 32'(fault), 32'd1);
      checkOutput("D_fault_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("D_fault_hold", 32'(state), 32'd6);
      checkOutput("D_fault_start", 32'(sobel_start), 32'd0);
      exp_states.push_back(3'd0);
      run = 1'b0;
      waitState(3'd0, 10, "D_release");
      checkOutput("D_fault_clear", 32'(fault), 32'd0);
`else
      exp_states.push_back(3'd0);
`endif
      run = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      exp_fc = 0;
      eng_en = 1'b1;
      @(negedge clk);
      checkOutput("D_reset_state", 32'(state), 32'd0);
      checkOutput("D_reset_fc", 32'(frame_count), 32'd0);

      // Asynchronous reset in the middle of CAPTURE
      exp_states.push_back(3'd1);
      exp_states.push_back(3'd2);
      exp_states.push_back(3'd0);
      applyStimulus(1'b1, 1'b0);
      waitState(3'd2, 100, "E_capture");
      repeat (4) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("E_async_we", 32'(static_we), 32'd0);
      checkOutput("E_async_state", 32'(state), 32'd0);
      checkOutput("E_async_busy", 32'(busy), 32'd0);
      run = 1'b0;
      @(posedge clk);
      #3 reset = 1'b0;
      @(negedge clk);
      checkOutput("E_fc", 32'(frame_count), 32'd0);

      // 256 passes wrap the 8-bit counter back to zero
      for (int i = 0; i < 256; i++) expectPass(i == 255);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 255; i++) waitState(3'd5, 120, "F_pass");
      waitState(3'd3, 120, "F_last_sobel");
      run = 1'b0;
      waitState(3'd0, 200, "F_idle");
      checkOutput("F_wrap", 32'(frame_count), 32'd0);

      repeat (5) @(negedge clk);
      checkOutput("sb_states_left", 32'(exp_states.size()), 32'd0);
      checkOutput("sb_fc_left", 32'(exp_fc_q.size()), 32'd0);
      checkOutput("sb_cap_left", 32'(exp_cap_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
